// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: scans every interior window of a source image held
// in a registered-read RAM, multiply-accumulates the nine pixels against a
// latched signed kernel, scales/clamps the sum and writes one 8-bit result per
// window into a dense destination RAM.
module conv3x3_engine #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [71:0]       kernel,
  input  logic [3:0]        shift,
  output logic              busy,
  output logic              done,
  output logic              src_r_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  output logic              dst_w_en,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [7:0]        dst_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ACC   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Address step from the last tap of one kernel row to the first of the next.
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 3);

  // Unsigned pixel times signed coefficient, added into the 20-bit sum.
  function automatic logic signed [19:0] mac(input logic signed [19:0] acc,
                                             input logic [7:0]         px,
                                             input logic signed [7:0]  coef);
    logic signed [16:0] px_s;
    logic signed [16:0] coef_s;
    logic signed [16:0] prod;
    px_s   = $signed({9'b0, px});
    coef_s = {{9{coef[7]}}, coef};
    prod   = px_s * coef_s;
    return acc + {{3{prod[16]}}, prod};
  endfunction

  // Arithmetic right shift (floor) followed by clamping to [0,255].
  function automatic logic [7:0] scale_sat(input logic signed [19:0] sum,
                                           input logic [3:0]         sh);
    logic signed [19:0] t;
    t = sum >>> sh;
    if (t[19])
      return 8'd0;
    else if (t[18:8] != 11'd0)
      return 8'hFF;
    else
      return t[7:0];
  endfunction

  logic [2:0]         state_q,    state_d;
  logic [ADDR_W-1:0]  src_addr_q, src_addr_d;
  logic [ADDR_W-1:0]  base_q,     base_d;
  logic [ADDR_W-1:0]  col_q,      col_d;
  logic [ADDR_W-1:0]  row_q,      row_d;
  logic [ADDR_W-1:0]  dst_addr_q, dst_addr_d;
  logic [7:0]         dst_data_q, dst_data_d;
  logic [3:0]         tap_q,      tap_d;
  logic [1:0]         dx_q,       dx_d;
  logic signed [19:0] acc_q,      acc_d;
  logic [71:0]        kernel_q,   kernel_d;
  logic [3:0]         shift_q,    shift_d;

  logic [3:0]         coef_idx;
  logic signed [7:0]  coef;
  logic signed [19:0] mac_sum;
  logic               last_win;

  // In FETCH the arriving data belongs to the previous tap; in ACC it is tap 8.
  assign coef_idx = (state_q == S_ACC) ? 4'd8 : (tap_q - 4'd1);
  assign coef     = $signed(kernel_q[{coef_idx, 3'b000} +: 8]);
  assign mac_sum  = mac(acc_q, src_data, coef);
  assign last_win = (row_q == LAST_ROW) && (col_q == LAST_COL);

  // Next-state logic for the scan FSM, address counters and datapath.
  always_comb begin
    state_d    = state_q;
    src_addr_d = src_addr_q;
    base_d     = base_q;
    col_d      = col_q;
    row_d      = row_q;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    tap_d      = tap_q;
    dx_d       = dx_q;
    acc_d      = acc_q;
    kernel_d   = kernel_q;
    shift_d    = shift_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          kernel_d   = kernel;
          shift_d    = shift;
          src_addr_d = '0;
          base_d     = '0;
          col_d      = '0;
          row_d      = '0;
          dst_addr_d = '0;
          tap_d      = 4'd0;
          dx_d       = 2'd0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        acc_d = (tap_q == 4'd0) ? 20'sd0 : mac_sum;
        if (tap_q == 4'd8) begin
          // Hold the address on the last tap so it never runs past the window.
          state_d = S_ACC;
        end else begin
          tap_d = tap_q + 4'd1;
          if (dx_q == 2'd2) begin
            dx_d       = 2'd0;
            src_addr_d = src_addr_q + ROW_STEP;
          end else begin
            dx_d       = dx_q + 2'd1;
            src_addr_d = src_addr_q + 1'b1;
          end
        end
      end
      S_ACC: begin
        dst_data_d = scale_sat(mac_sum, shift_q);
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (last_win) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_FETCH;
          tap_d      = 4'd0;
          dx_d       = 2'd0;
          dst_addr_d = dst_addr_q + 1'b1;
          if (col_q == LAST_COL) begin
            // Skip the two right-edge origins to reach the next row start.
            col_d      = '0;
            row_d      = row_q + 1'b1;
            base_d     = base_q + ADDR_W'(3);
            src_addr_d = base_q + ADDR_W'(3);
          end else begin
            col_d      = col_q + 1'b1;
            base_d     = base_q + 1'b1;
            src_addr_d = base_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_addr_q <= '0;
      base_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      dst_addr_q <= '0;
      dst_data_q <= 8'd0;
      tap_q      <= 4'd0;
      dx_q       <= 2'd0;
    end else begin
      state_q    <= state_d;
      src_addr_q <= src_addr_d;
      base_q     <= base_d;
      col_q      <= col_d;
      row_q      <= row_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
      tap_q      <= tap_d;
      dx_q       <= dx_d;
    end
  end

  // Accumulator and latched frame settings carry no reset; they are
  // (re)initialised by start and by tap 0 of every window.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    kernel_q <= kernel_d;
    shift_q  <= shift_d;
  end

  assign busy     = (state_q == S_FETCH) || (state_q == S_ACC) || (state_q == S_WRITE);
  assign done     = (state_q == S_DONE);
  assign src_r_en = (state_q == S_FETCH);
  assign src_addr = src_addr_q;
  assign dst_w_en = (state_q == S_WRITE);
  assign dst_addr = dst_addr_q;
  assign dst_data = dst_data_q;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine on a 5x4 image with source/destination
// RAM models and a write scoreboard.
module tb_conv3x3_engine;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int P  = (W - 2) * (H - 2);
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [71:0]   kernel = '0;
  logic [3:0]    shift = 4'd0;
  logic          busy, done, src_r_en, dst_w_en;
  logic [AW-1:0] src_addr, dst_addr;
  logic [7:0]    src_data = 8'd0;
  logic [7:0]    dst_data;

  conv3x3_engine #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .kernel   (kernel),
    .shift    (shift),
    .busy     (busy),
    .done     (done),
    .src_r_en (src_r_en),
    .src_addr (src_addr),
    .src_data (src_data),
    .dst_w_en (dst_w_en),
    .dst_addr (dst_addr),
    .dst_data (dst_data)
  );

  always #5 clk = ~clk;

  logic [7:0] img  [W*H];
  logic [7:0] dmem [P];

  always @(posedge clk)
    if (src_r_en && src_addr < AW'(W*H)) src_data <= img[src_addr];

  always @(posedge clk)
    if (dst_w_en && dst_addr < AW'(P)) dmem[dst_addr] <= dst_data;

  int cyc = 0;
  int t0  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } exp_t;
  exp_t q[$];

  int tests  = 0;
  int fails  = 0;
  int wr_cnt = 0;

  localparam logic [71:0] K_ID   = 72'd1 << 32;
  localparam logic [71:0] K_BOX  = {9{8'd1}};
  localparam logic [71:0] K_NEG  = 72'hFF << 32;
  localparam logic [71:0] K_SEV  = 72'd7 << 32;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Independent reference for one window result.
  function automatic logic [7:0] model(input int r, input int c,
                                       input logic [71:0] k, input logic [3:0] s);
    int sum;
    logic [7:0] kb;
    sum = 0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++) begin
        kb  = k[8*(3*dy+dx) +: 8];
        sum += int'(img[(r+dy)*W + c + dx]) * int'($signed(kb));
      end
    sum = sum >>> s;
    if (sum < 0) return 8'd0;
    if (sum > 255) return 8'd255;
    return 8'(sum);
  endfunction

  task automatic push_expect(input logic [71:0] k, input logic [3:0] s);
    exp_t e;
    for (int r = 0; r < H - 2; r++)
      for (int c = 0; c < W - 2; c++) begin
        e.a = AW'(r*(W-2) + c);
        e.d = model(r, c, k, s);
        q.push_back(e);
      end
  endtask

  task automatic fill(input bit ramp, input logic [7:0] val);
    for (int i = 0; i < W*H; i++) img[i] = ramp ? 8'(i + 10) : val;
  endtask

  // Monitor: scoreboard every write, and enables must never overlap.
  always @(negedge clk) begin
    exp_t e;
    if (src_r_en || dst_w_en) chk("exclusive_en", 32'(src_r_en & dst_w_en), 0);
    if (dst_w_en) begin
      wr_cnt++;
      if (q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = q.pop_front();
        chk("wr_addr", 32'(dst_addr), 32'(e.a));
        chk("wr_data", 32'(dst_data), 32'(e.d));
      end
    end
  end

  task automatic start_frame(input logic [71:0] k, input logic [3:0] s);
    @(negedge clk);
    t0     = cyc;
    kernel = k;
    shift  = s;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_cycle(input int n);
    @(negedge clk);
    while (cyc - t0 < n) @(negedge clk);
  endtask

  task automatic wait_done(output int at);
    int i;
    i = 0;
    @(negedge clk);
    while (!done && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk("done_seen", 32'(done), 1);
    at = cyc - t0;
  endtask

  task automatic run_frame(input logic [71:0] k, input logic [3:0] s);
    int at;
    push_expect(k, s);
    wr_cnt = 0;
    start_frame(k, s);
    wait_done(at);
    chk("done_cycle", 32'(at), 11*P + 1);
    chk("write_count", 32'(wr_cnt), P);
    chk("queue_empty", 32'(q.size()), 0);
  endtask

  initial begin
    int at;
    logic [7:0] id_exp [P];
    id_exp = '{8'd16, 8'd17, 8'd18, 8'd21, 8'd22, 8'd23};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_src_r_en", 32'(src_r_en), 0);
    chk("rst_src_addr", 32'(src_addr), 0);
    chk("rst_dst_w_en", 32'(dst_w_en), 0);
    chk("rst_dst_addr", 32'(dst_addr), 0);
    chk("rst_dst_data", 32'(dst_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Identity kernel with cycle timing, ignored start and kernel latching.
    fill(1'b1, 8'd0);
    push_expect(K_ID, 4'd0);
    wr_cnt = 0;
    start_frame(K_ID, 4'd0);
    wait_cycle(1);
    chk("c1_busy", 32'(busy), 1);
    chk("c1_src_r_en", 32'(src_r_en), 1);
    chk("c1_src_addr", 32'(src_addr), 0);
    wait_cycle(10);
    chk("c10_dst_w_en", 32'(dst_w_en), 0);
    wait_cycle(11);
    chk("c11_dst_w_en", 32'(dst_w_en), 1);
    kernel = K_BOX;
    shift  = 4'd3;
    wait_cycle(30);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(at);
    chk("done_cycle", 32'(at), 67);
    @(negedge clk);
    chk("done_pulse_end", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("write_count", 32'(wr_cnt), P);
    chk("queue_empty", 32'(q.size()), 0);
    for (int i = 0; i < P; i++) chk("id_dmem", 32'(dmem[i]), 32'(id_exp[i]));
    repeat (5) @(negedge clk);
    chk("no_restart", 32'(busy), 0);

    // Box kernel, scaled.
    fill(1'b0, 8'd200);
    run_frame(K_BOX, 4'd3);
    chk("box_dmem0", 32'(dmem[0]), 225);
    chk("box_dmem5", 32'(dmem[P-1]), 225);

    // Clamp high, clamp low, floor.
    run_frame(K_BOX, 4'd0);
    chk("sat_hi_dmem", 32'(dmem[3]), 255);
    fill(1'b0, 8'd50);
    run_frame(K_NEG, 4'd0);
    chk("sat_lo_dmem", 32'(dmem[2]), 0);
    fill(1'b0, 8'd1);
    run_frame(K_SEV, 4'd1);
    chk("floor_dmem", 32'(dmem[4]), 3);

    // Reset during window 2 abandons the frame.
    fill(1'b1, 8'd0);
    push_expect(K_ID, 4'd0);
    wr_cnt = 0;
    start_frame(K_ID, 4'd0);
    wait_cycle(25);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_src_r_en", 32'(src_r_en), 0);
    chk("mid_rst_src_addr", 32'(src_addr), 0);
    chk("mid_rst_dst_w_en", 32'(dst_w_en), 0);
    chk("mid_rst_dst_addr", 32'(dst_addr), 0);
    chk("mid_rst_dst_data", 32'(dst_data), 0);
    chk("mid_rst_done", 32'(done), 0);
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("writes_before_rst", 32'(wr_cnt), 2);
    run_frame(K_ID, 4'd0);
    for (int i = 0; i < P; i++) chk("post_rst_dmem", 32'(dmem[i]), 32'(id_exp[i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv3x3_engine.md
# conv3x3_engine

3x3 convolution engine sitting between the source image RAM (8-bit single-channel pixels, 12-bit address, registered read with one-cycle latency) and a destination result RAM of the same type. On a start pulse it scans every interior window of an IMG_W x IMG_H source image. It reads the nine pixels of each window, multiply-accumulates them against a signed kernel, then scales, clamps and writes one 8-bit result per window. It asserts `done` when the frame is finished.

## Interface

- `IMG_W`, 64, source image width in pixels; must be ≥3.
- `IMG_H`, 64, source image height in pixels; must be ≥3; IMG_W*IMG_H ≤ 2^ADDR_W.
- `ADDR_W`, 12, RAM address width.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `kernel`  in  72  nine signed 8-bit coefficients, row-major; k0 = [7:0] is top-left, k8 = [71:64] is bottom-right. Latched on accepted start.
- `shift`  in  4  arithmetic right-shift applied to the sum; latched on accepted start.
- `busy`  out  1  high from the first fetch through the last write.
- `done`  out  1  one-cycle pulse after the last write.
- `src_r_en`  out  1  read enable to the source RAM.
- `src_addr`  out  ADDR_W  source read address.
- `src_data`  in  8  source RAM data_out; valid the cycle after the matching src_r_en.
- `dst_w_en`  out  1  write enable to the destination RAM.
- `dst_addr`  out  ADDR_W  destination write address.
- `dst_data`  out  8  result pixel.

## Operation

- Window origin (r,c) scans r = 0..IMG_H-3 (outer) and c = 0..IMG_W-3 (inner). P = (IMG_W-2)*(IMG_H-2) results per frame.
- Tap k = 3*dy+dx, read from src address (r+dy)*IMG_W + (c+dx). Taps are fetched in order k = 0..8.
- Result address is r*(IMG_W-2)+c, so results are dense and run from 0 to P-1. Addresses are generated by incremental counters; no multiplier is used.
- Arithmetic: src_data is unsigned (zero-extended) and the coefficient is signed. Products are summed in a 20-bit signed accumulator, which cannot overflow. The accumulator is cleared before tap 0 of each window.
- Scaling: the sum is arithmetic-shifted right by `shift` (floor toward −inf), then clamped to [0,255].
- FSM states:
  - IDLE: outputs idle; start=1 latches kernel/shift, zeroes counters, and moves to FETCH.
  - FETCH (9 cycles): src_r_en=1, src_addr = tap k. The src_data for tap k−1 is accumulated on the same edge.
  - ACC (1 cycle): src_r_en=0. Tap 8 is accumulated, and the scaled/clamped value is registered into dst_data on the same edge.
  - WRITE (1 cycle): dst_w_en=1 with dst_addr/dst_data. Goes to FETCH for the next window, or to DONE after window P−1.
  - DONE (1 cycle): done=1, busy=0; then IDLE.
- `start` outside IDLE (including DONE) is ignored. `kernel`/`shift` changes after acceptance have no effect on the running frame.
- Reset mid-frame: all outputs clear immediately and the FSM enters IDLE. No further reads or writes occur, and the partial frame is abandoned. The next start restarts at window 0.

## Timing

- Reset values: busy=0, done=0, src_r_en=0, src_addr=0, dst_w_en=0, dst_addr=0, dst_data=0; FSM in IDLE.
- Start is accepted on edge E0. The cycle after E0 is cycle 1, which is FETCH tap 0 with busy=1.
- Each window takes 11 cycles: 9 FETCH, 1 ACC, 1 WRITE.
- Window n (counted from 0) occupies cycles 11n+1 .. 11n+11. Its write is in cycle 11n+11.
- done=1 in cycle 11P+1; the block is in IDLE and ready for start at cycle 11P+2.
- src_r_en and dst_w_en are never high in the same cycle.
- Edge cases:
  - With IMG_W=3, IMG_H=3: P=1 and done is in cycle 12.
  - The last read address is IMG_W*IMG_H−1 and never exceeds it; no address wraps.

## Test plan

- Identity kernel (k4=1, others 0), shift=0, IMG_W=5, IMG_H=4, src[i]=i+10 → dst[r*3+c] = src[(r+1)*5+c+1]; 6 writes holding 16,17,18,21,22,23.
- Box kernel (all 1), shift=3, constant image 200 → every result = 1800>>3 = 225.
- Clamp behaviour:
  - Box kernel with shift=0 on image 200 → all results 255.
  - k4=−1 on image 50 → all results 0.
  - k4=7, shift=1 on image 1 → result 3 (floor).
- Cycle timing, 5x4:
  - busy rises cycle 1 and first src_addr=0.
  - First dst write is in cycle 11; done pulses for one cycle in cycle 67.
  - A start pulsed at cycle 30 is ignored.
- Reset: deassert rst_n during window 2 (cycle 25) → all outputs 0 immediately and no further writes. A start after release gives its first write at dst_addr 0 with correct data.
- Kernel latching: change `kernel` mid-frame → results still match the kernel latched at start.
